// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and opcode codes for the CPU run/halt/step controller
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  typedef logic [2:0] cmd_op_t;

  localparam cmd_op_t OP_NOP   = 3'd0;
  localparam cmd_op_t OP_RUN   = 3'd1;
  localparam cmd_op_t OP_HALT  = 3'd2;
  localparam cmd_op_t OP_STEP  = 3'd3;
  localparam cmd_op_t OP_SETBP = 3'd4;
  localparam cmd_op_t OP_CLRBP = 3'd5;
  localparam cmd_op_t OP_RES6  = 3'd6;
  localparam cmd_op_t OP_RES7  = 3'd7;

  typedef enum logic [1:0] {
    HC_RESET = 2'd0,
    HC_CMD   = 2'd1,
    HC_BP    = 2'd2,
    HC_CORE  = 2'd3
  } halt_cause_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, cleared only by reset
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/halt/single-step controller owning the core clock-enable
// One FSM plus a single PC breakpoint; retired instructions counted by sat_counter.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [PC_W-1:0]  cmd_arg,
  input  logic             instr_done,
  input  logic [PC_W-1:0]  next_pc,
  input  logic             core_halt,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [1:0]       halt_cause,
  output logic             bp_en,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t          state_q, state_d;
  halt_cause_t     cause_q, cause_d;
  logic            bp_en_q, bp_en_d;
  logic [PC_W-1:0] bp_addr_q, bp_addr_d;

  logic cmd_fire;
  logic bp_hit;

  assign cmd_fire = cmd_valid && cmd_ready;
  // Stops compare against the registered breakpoint, so a same-cycle SETBP/CLRBP acts next cycle.
  assign bp_hit   = instr_done && bp_en_q && (next_pc == bp_addr_q);

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    bp_en_d   = bp_en_q;
    bp_addr_d = bp_addr_q;

    if (cmd_fire) begin
      case (cmd_op)
        OP_SETBP: begin
          bp_addr_d = cmd_arg;
          bp_en_d   = 1'b1;
        end
        OP_CLRBP: bp_en_d = 1'b0;
        OP_NOP, OP_RUN, OP_HALT, OP_STEP, OP_RES6, OP_RES7: ;
      endcase
    end

    case (state_q)
      ST_HALTED: begin
        if (cmd_fire && (cmd_op == OP_RUN)) begin
          state_d = ST_RUN;
        end else if (cmd_fire && (cmd_op == OP_STEP)) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN, ST_STEP: begin
        if (core_halt) begin
          state_d = ST_HALTED;
          cause_d = HC_CORE;
        end else if (bp_hit) begin
          state_d = ST_HALTED;
          cause_d = HC_BP;
        end else if ((state_q == ST_STEP) && instr_done) begin
          state_d = ST_HALTED;
          cause_d = HC_CMD;
        end else if ((state_q == ST_RUN) && cmd_fire && (cmd_op == OP_HALT)) begin
          state_d = ST_HALTED;
          cause_d = HC_CMD;
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HALTED;
      cause_q   <= HC_RESET;
      bp_en_q   <= 1'b0;
      bp_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      bp_en_q   <= bp_en_d;
      bp_addr_q <= bp_addr_d;
    end
  end

  assign cpu_en     = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign cmd_ready  = (state_q != ST_STEP);
  assign state      = state_q;
  assign halt_cause = cause_q;
  assign bp_en      = bp_en_q;

  sat_counter #(
    .W(CNT_W)
  ) u_instr_cnt (
    .clk(clk),
    .rst(rst),
    .inc(instr_done && cpu_en),
    .q  (instr_cnt)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready, cmd_ready4;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_arg;
  logic        instr_done;
  logic [7:0]  next_pc;
  logic        core_halt;
  logic        cpu_en, cpu_en4;
  logic [1:0]  state, state4;
  logic [1:0]  halt_cause, halt_cause4;
  logic        bp_en, bp_en4;
  logic [15:0] instr_cnt;
  logic [3:0]  instr_cnt4;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.PC_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .instr_done(instr_done), .next_pc(next_pc),
    .core_halt(core_halt), .cpu_en(cpu_en), .state(state), .halt_cause(halt_cause),
    .bp_en(bp_en), .instr_cnt(instr_cnt)
  );

  cpu_run_ctrl #(.PC_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .instr_done(instr_done), .next_pc(next_pc),
    .core_halt(core_halt), .cpu_en(cpu_en4), .state(state4), .halt_cause(halt_cause4),
    .bp_en(bp_en4), .instr_cnt(instr_cnt4)
  );

  typedef struct packed {
    logic        rst;
    logic        cv;
    logic [2:0]  op;
    logic [7:0]  arg;
    logic        done;
    logic [7:0]  pc;
    logic        ch;
    logic [1:0]  st;
    logic        en;
    logic        rdy;
    logic [1:0]  hc;
    logic        bp;
    logic [15:0] cnt;
  } row_t;

  typedef struct {
    string       tag;
    logic [22:0] v;
  } exp_t;

  row_t       rows[$];
  exp_t       sb[$];
  logic [3:0] sb4[$];
  int errors = 0;
  int checks = 0;

  task automatic add(input logic r, input logic cv, input logic [2:0] op, input logic [7:0] arg,
                     input logic done, input logic [7:0] pc, input logic ch,
                     input logic [1:0] st, input logic en, input logic rdy,
                     input logic [1:0] hc, input logic bp, input logic [15:0] cnt);
    row_t x;
    x = '{r, cv, op, arg, done, pc, ch, st, en, rdy, hc, bp, cnt};
    rows.push_back(x);
  endtask

  task automatic apply(input row_t r, input string tag);
    exp_t e;
    rst        = r.rst;
    cmd_valid  = r.cv;
    cmd_op     = r.op;
    cmd_arg    = r.arg;
    instr_done = r.done;
    next_pc    = r.pc;
    core_halt  = r.ch;
    e.tag = tag;
    e.v   = {r.st, r.en, r.rdy, r.hc, r.bp, r.cnt};
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [22:0] obs();
    return {state, cpu_en, cmd_ready, halt_cause, bp_en, instr_cnt};
  endfunction

  // fields: rst cv op arg done pc ch | st en rdy hc bp cnt
  task automatic test_reset();
    exp_t e;
    rows.delete();
    add(1, 0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 0, 0, 0);
    foreach (rows[i]) begin
      apply(rows[i], "reset");
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL %s[%0d] got st,en,rdy,hc,bp,cnt=%h required=%h", e.tag, i, obs(), e.v);
      end
    end
  endtask

  task automatic test_step();
    exp_t e;
    rows.delete();
    add(1, 0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 0, 0, 0);
    add(0, 1, 3, 8'h00, 0, 8'h00, 0,  2, 1, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 0, 8'h00, 0,  2, 1, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 0, 8'h00, 0,  2, 1, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 1, 8'h05, 0,  0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 8'h00, 0, 8'h05, 0,  0, 0, 1, 1, 0, 1);
    add(0, 1, 3, 8'h00, 1, 8'h06, 0,  2, 1, 0, 1, 0, 1);
    add(0, 1, 1, 8'h00, 1, 8'h07, 0,  0, 0, 1, 1, 0, 2);
    add(0, 0, 0, 8'h00, 0, 8'h07, 0,  0, 0, 1, 1, 0, 2);
    foreach (rows[i]) begin
      apply(rows[i], "step");
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL %s[%0d] got st,en,rdy,hc,bp,cnt=%h required=%h", e.tag, i, obs(), e.v);
      end
    end
  endtask

  task automatic test_breakpoint();
    exp_t e;
    rows.delete();
    add(1, 0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 0, 0, 0);
    add(0, 1, 4, 8'h2A, 0, 8'h00, 0,  0, 0, 1, 0, 1, 0);
    add(0, 1, 1, 8'h00, 0, 8'h27, 0,  1, 1, 1, 0, 1, 0);
    add(0, 0, 0, 8'h00, 1, 8'h28, 0,  1, 1, 1, 0, 1, 1);
    add(0, 0, 0, 8'h00, 1, 8'h29, 0,  1, 1, 1, 0, 1, 2);
    add(0, 0, 0, 8'h00, 1, 8'h2A, 0,  0, 0, 1, 2, 1, 3);
    add(0, 1, 1, 8'h00, 0, 8'h2A, 0,  1, 1, 1, 2, 1, 3);
    add(0, 0, 0, 8'h00, 0, 8'h2A, 0,  1, 1, 1, 2, 1, 3);
    add(0, 0, 0, 8'h00, 1, 8'h2B, 0,  1, 1, 1, 2, 1, 4);
    add(0, 1, 3, 8'h00, 0, 8'h2B, 0,  1, 1, 1, 2, 1, 4);
    add(0, 1, 2, 8'h00, 0, 8'h2B, 0,  0, 0, 1, 1, 1, 4);
    add(0, 1, 2, 8'h00, 0, 8'h2B, 0,  0, 0, 1, 1, 1, 4);
    foreach (rows[i]) begin
      apply(rows[i], "bp");
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL %s[%0d] got st,en,rdy,hc,bp,cnt=%h required=%h", e.tag, i, obs(), e.v);
      end
    end
  endtask

  task automatic test_core_halt();
    exp_t e;
    rows.delete();
    add(1, 0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 8'h00, 0, 8'h00, 0,  1, 1, 1, 0, 0, 0);
    add(0, 1, 2, 8'h00, 0, 8'h00, 1,  0, 0, 1, 3, 0, 0);
    add(0, 0, 0, 8'h00, 1, 8'h00, 1,  0, 0, 1, 3, 0, 0);
    add(0, 1, 3, 8'h00, 0, 8'h00, 0,  2, 1, 0, 3, 0, 0);
    add(0, 0, 0, 8'h00, 1, 8'h01, 1,  0, 0, 1, 3, 0, 1);
    foreach (rows[i]) begin
      apply(rows[i], "core_halt");
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL %s[%0d] got st,en,rdy,hc,bp,cnt=%h required=%h", e.tag, i, obs(), e.v);
      end
    end
  endtask

  task automatic test_clrbp();
    exp_t e;
    rows.delete();
    add(1, 0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 0, 0, 0);
    add(0, 1, 4, 8'h10, 0, 8'h00, 0,  0, 0, 1, 0, 1, 0);
    add(0, 1, 1, 8'h00, 0, 8'h00, 0,  1, 1, 1, 0, 1, 0);
    add(0, 1, 5, 8'h00, 1, 8'h10, 0,  0, 0, 1, 2, 0, 1);
    add(0, 1, 1, 8'h00, 0, 8'h10, 0,  1, 1, 1, 2, 0, 1);
    add(0, 0, 0, 8'h00, 1, 8'h10, 0,  1, 1, 1, 2, 0, 2);
    add(0, 1, 4, 8'h20, 0, 8'h11, 0,  1, 1, 1, 2, 1, 2);
    add(0, 1, 5, 8'h00, 0, 8'h11, 0,  1, 1, 1, 2, 0, 2);
    add(0, 0, 0, 8'h00, 1, 8'h20, 0,  1, 1, 1, 2, 0, 3);
    add(0, 1, 2, 8'h00, 0, 8'h21, 0,  0, 0, 1, 1, 0, 3);
    add(0, 1, 6, 8'h55, 0, 8'h21, 0,  0, 0, 1, 1, 0, 3);
    foreach (rows[i]) begin
      apply(rows[i], "clrbp");
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL %s[%0d] got st,en,rdy,hc,bp,cnt=%h required=%h", e.tag, i, obs(), e.v);
      end
    end
  endtask

  task automatic test_saturate_and_reset();
    exp_t       e;
    logic [3:0] e4;
    rows.delete();
    add(1, 0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 8'h00, 0, 8'h00, 0,  1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      add(0, 0, 0, 8'h00, 1, 8'(8'h40 + i), 0,  1, 1, 1, 0, 0, 16'(i + 1));
    end
    add(1, 1, 2, 8'h00, 1, 8'h00, 1,  0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 0, 0, 0);
    foreach (rows[i]) begin
      apply(rows[i], "sat");
      sb4.push_back((rows[i].cnt > 16'd15) ? 4'hF : rows[i].cnt[3:0]);
      tick();
      e  = sb.pop_front();
      e4 = sb4.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL %s[%0d] got st,en,rdy,hc,bp,cnt=%h required=%h", e.tag, i, obs(), e.v);
      end
      checks++;
      if (instr_cnt4 !== e4) begin
        errors++;
        $display("FAIL sat_cnt4[%0d] got=%0d required=%0d", i, instr_cnt4, e4);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 3'd0;
    cmd_arg    = 8'h00;
    instr_done = 1'b0;
    next_pc    = 8'h00;
    core_halt  = 1'b0;
    test_reset();
    test_step();
    test_breakpoint();
    test_core_halt();
    test_clrbp();
    test_saturate_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
